// File: rtl/ibr128_pkg.sv
// rtl/ibr128_pkg.sv - shared constants and state encoding for the IBR128 sequencer
package ibr128_pkg;

  localparam int BLK_W = 128;

  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/ibr128_seq_if.sv
// rtl/ibr128_seq_if.sv - block stream and cipher core handshakes of the IBR128 sequencer
interface ibr128_seq_if;
  import ibr128_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;
  logic             core_start;
  logic             core_encrypt;
  logic [BLK_W-1:0] core_din;
  logic             core_done;
  logic [BLK_W-1:0] core_dout;

  modport master (
    input  in_valid, in_data, out_ready, core_done, core_dout,
    output in_ready, out_valid, out_data, core_start, core_encrypt, core_din
  );

  modport slave (
    output in_valid, in_data, out_ready, core_done, core_dout,
    input  in_ready, out_valid, out_data, core_start, core_encrypt, core_din
  );

endinterface

// File: rtl/ibr128_chain.sv
// rtl/ibr128_chain.sv - chaining-mode mux around the core and the chain/counter register
module ibr128_chain
  import ibr128_pkg::*;
(
  input  logic             Clk,
  input  logic             RstN,
  input  logic             i_load,
  input  logic [BLK_W-1:0] i_iv,
  input  logic             i_update,
  input  logic [1:0]       i_mode,
  input  logic             i_encrypt,
  input  logic [BLK_W-1:0] i_blk,
  input  logic [BLK_W-1:0] i_core_dout,
  output logic [BLK_W-1:0] o_core_din,
  output logic [BLK_W-1:0] o_result,
  output logic             o_core_encrypt
);

  logic [BLK_W-1:0] r_chain;
  logic [BLK_W-1:0] w_chain_nxt;

  // Reserved mode 2'b11 falls through to the ECB defaults.
  always_comb begin
    o_core_din     = i_blk;
    o_result       = i_core_dout;
    o_core_encrypt = i_encrypt;
    w_chain_nxt    = r_chain;
    case (i_mode)
      MODE_CBC: begin
        if (i_encrypt) begin
          o_core_din  = i_blk ^ r_chain;
          w_chain_nxt = i_core_dout;
        end else begin
          o_result    = i_core_dout ^ r_chain;
          w_chain_nxt = i_blk;
        end
      end
      MODE_CTR: begin
        o_core_din     = r_chain;
        o_result       = i_core_dout ^ i_blk;
        o_core_encrypt = 1'b1;
        w_chain_nxt    = r_chain + {{(BLK_W-1){1'b0}}, 1'b1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_chain <= '0;
    end else if (i_load) begin
      r_chain <= i_iv;
    end else if (i_update) begin
      r_chain <= w_chain_nxt;
    end
  end

endmodule

// File: rtl/ibr128_seq.sv
// rtl/ibr128_seq.sv - multi-block ECB/CBC/CTR sequencer driving a single-block IBR128 core
module ibr128_seq
  import ibr128_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int TO_CYCLES = 1024
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Encrypt,
  input  logic [1:0]       Mode,
  input  logic [BLK_W-1:0] IV,
  input  logic [CNT_W-1:0] BlkCount,
  ibr128_seq_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] remaining
);

  localparam int TO_W = $clog2(TO_CYCLES + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_enc;
  logic [1:0]       r_mode;
  logic [BLK_W-1:0] r_blk;
  logic [BLK_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_rem;
  logic             r_err;
  logic [TO_W-1:0]  r_to_cnt;

  logic             w_accept_start;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_core_fin;
  logic             w_timeout;
  logic [BLK_W-1:0] w_result;

  assign w_accept_start = (r_state == S_IDLE) && Start && !Abort;
  assign w_in_hs        = (r_state == S_LOAD) && bus.in_valid;
  assign w_out_hs       = (r_state == S_OUT) && bus.out_ready;
  assign w_core_fin     = (r_state == S_WAIT) && bus.core_done;
  assign w_timeout      = (r_state == S_WAIT) && !bus.core_done &&
                          (r_to_cnt == TO_W'(TO_CYCLES - 1));

  ibr128_chain u_chain (
    .Clk           (Clk),
    .RstN          (RstN),
    .i_load        (w_accept_start),
    .i_iv          (IV),
    .i_update      (w_core_fin && !Abort),
    .i_mode        (r_mode),
    .i_encrypt     (r_enc),
    .i_blk         (r_blk),
    .i_core_dout   (bus.core_dout),
    .o_core_din    (bus.core_din),
    .o_result      (w_result),
    .o_core_encrypt(bus.core_encrypt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = (BlkCount == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (bus.in_valid) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.core_done) w_state_nxt = S_OUT;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_OUT:   if (bus.out_ready) w_state_nxt = (r_rem == CNT_W'(1)) ? S_DONE : S_LOAD;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides every transition, including a Start in IDLE.
    if (Abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_enc      <= 1'b0;
      r_mode     <= MODE_ECB;
      r_blk      <= '0;
      r_out_data <= '0;
      r_rem      <= '0;
      r_err      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      if (w_accept_start) begin
        r_enc  <= Encrypt;
        r_mode <= Mode;
        r_rem  <= BlkCount;
        r_err  <= 1'b0;
      end
      if (w_in_hs && !Abort) r_blk <= bus.in_data;
      if (r_state == S_START) r_to_cnt <= '0;
      else if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_core_fin && !Abort) r_out_data <= w_result;
      if (w_out_hs && !Abort) r_rem <= r_rem - CNT_W'(1);
      if (w_timeout && !Abort) r_err <= 1'b1;
    end
  end

  assign bus.in_ready   = (r_state == S_LOAD);
  assign bus.out_valid  = (r_state == S_OUT);
  assign bus.out_data   = r_out_data;
  assign bus.core_start = (r_state == S_START);
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign err            = r_err;
  assign remaining      = r_rem;

endmodule

// File: tb/tb_ibr128_seq.sv
// tb/tb_ibr128_seq.sv - self-checking bench for ibr128_seq with an XOR-key core model
module tb_ibr128_seq;
  import ibr128_pkg::*;

  localparam logic [127:0] K  = {4{32'hA5A5A5A5}};
  localparam logic [127:0] A  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] B  = 128'hFEDCBA98765432100011223344556677;
  localparam logic [127:0] C  = 128'h00000000FFFFFFFF123412341234ABCD;
  localparam logic [127:0] D  = 128'h80000000000000000000000000000001;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic         Start = 1'b0;
  logic         Abort = 1'b0;
  logic         Encrypt = 1'b0;
  logic [1:0]   Mode = 2'b00;
  logic [127:0] IV = '0;
  logic [15:0]  BlkCount = '0;
  logic         busy, done, err;
  logic [15:0]  remaining;

  ibr128_seq_if bus ();

  ibr128_seq #(.CNT_W(16), .TO_CYCLES(16)) dut (
    .Clk      (Clk),
    .RstN     (RstN),
    .Start    (Start),
    .Abort    (Abort),
    .Encrypt  (Encrypt),
    .Mode     (Mode),
    .IV       (IV),
    .BlkCount (BlkCount),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .remaining(remaining)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit core_en = 1'b1;
  logic exp_cenc = 1'b0;
  logic [127:0] sb_q[$];
  logic [127:0] din_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [127:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h want no event", name, act);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Core model: result is din ^ K, done three cycles after core_start.
  initial begin
    logic [127:0] lat;
    int cd;
    lat = '0;
    cd = 0;
    bus.core_done = 1'b0;
    bus.core_dout = '0;
    forever begin
      @(negedge Clk);
      bus.core_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          chk("core_din_hold", bus.core_din, lat);
          bus.core_done = 1'b1;
          bus.core_dout = lat ^ K;
        end
      end
      if (bus.core_start === 1'b1) begin
        lat = bus.core_din;
        if (din_q.size() == 0) fail_evt("core_start_unexpected", bus.core_din);
        else chk("core_din", bus.core_din, din_q.pop_front());
        chk_b("core_encrypt", bus.core_encrypt, exp_cenc);
        if (core_en) cd = 3;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb_q.size() == 0) fail_evt("out_unexpected", bus.out_data);
        else chk("out_data", bus.out_data, sb_q.pop_front());
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic start_job(input logic [1:0] m, input logic e, input logic [127:0] iv,
                           input logic [15:0] n);
    Mode = m;
    Encrypt = e;
    IV = iv;
    BlkCount = n;
    exp_cenc = (m == MODE_CTR) ? 1'b1 : e;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Mode = 2'($urandom_range(0, 3));
    Encrypt = ~e;
    IV = {4{$urandom}};
    BlkCount = 16'($urandom);
  endtask

  task automatic feed(input logic [127:0] blk, input logic [127:0] exp_out,
                      input logic [127:0] exp_din, input bit expect_out);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      fail_evt("in_ready_wait", 128'(n));
    end else begin
      if (expect_out) sb_q.push_back(exp_out);
      din_q.push_back(exp_din);
      bus.in_valid = 1'b1;
      bus.in_data = blk;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data = {4{$urandom}};
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) fail_evt("idle_wait", 128'(n));
  endtask

  typedef struct {
    logic [1:0]         mode;
    logic               enc;
    logic [127:0]       iv;
    int                 n;
    logic [1:0][127:0]  blk;
    logic [1:0][127:0]  exp_out;
    logic [1:0][127:0]  exp_din;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0;
    int n;
    logic [127:0] held;

    vecs[0] = '{MODE_ECB, 1'b1, '0, 1, {128'h0, A}, {128'h0, A ^ K}, {128'h0, A}};
    vecs[1] = '{MODE_CBC, 1'b1, 128'h1, 2, {128'h0, 128'h0},
                {128'h1, 128'h1 ^ K}, {128'h1 ^ K, 128'h1}};
    vecs[2] = '{MODE_CBC, 1'b0, 128'h1, 2, {128'h1, 128'h1 ^ K},
                {128'h0, 128'h0}, {128'h1, 128'h1 ^ K}};
    vecs[3] = '{MODE_CTR, 1'b0, ONES, 2, {128'h0, 128'h0},
                {K, {4{32'h5A5A5A5A}}}, {128'h0, ONES}};
    vecs[4] = '{2'b11, 1'b0, 128'hDEAD, 1, {128'h0, B}, {128'h0, B ^ K}, {128'h0, B}};
    vecs[5] = '{MODE_CTR, 1'b1, 128'h5, 2, {D, C},
                {128'h6 ^ K ^ D, 128'h5 ^ K ^ C}, {128'h6, 128'h5}};

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_err", err, 1'b0);
    chk_i("rst_remaining", int'(remaining), 0);
    chk_b("rst_out_valid", bus.out_valid, 1'b0);
    chk_b("rst_in_ready", bus.in_ready, 1'b0);
    chk_b("rst_core_start", bus.core_start, 1'b0);
    chk("rst_core_din", bus.core_din, '0);
    chk("rst_out_data", bus.out_data, '0);
    RstN = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      start_job(vecs[v].mode, vecs[v].enc, vecs[v].iv, 16'(vecs[v].n));
      for (int b = 0; b < vecs[v].n; b++)
        feed(vecs[v].blk[b], vecs[v].exp_out[b], vecs[v].exp_din[b], 1'b1);
      wait_idle(n);
      chk_i($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
      chk_i($sformatf("v%0d_remaining", v), int'(remaining), 0);
      chk_i($sformatf("v%0d_outputs_left", v), sb_q.size(), 0);
    end

    // Backpressure: result must hold while out_ready is low.
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    start_job(MODE_ECB, 1'b1, '0, 16'd1);
    feed(C, C ^ K, C, 1'b1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      chk_b("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_out_data", bus.out_data, C ^ K);
      chk_b("bp_in_ready", bus.in_ready, 1'b0);
      chk_i("bp_remaining", int'(remaining), 1);
      tick();
    end
    chk("bp_out_stable", bus.out_data, held);
    bus.out_ready = 1'b1;
    wait_idle(n);
    chk_i("bp_done_pulses", done_cnt - d0, 1);

    // Timeout: core never answers.
    d0 = done_cnt;
    core_en = 1'b0;
    start_job(MODE_ECB, 1'b1, '0, 16'd1);
    feed(D, '0, D, 1'b0);
    wait_idle(n);
    chk_i("to_cycles_to_idle", n, 17);
    chk_b("to_err", err, 1'b1);
    chk_i("to_done_pulses", done_cnt - d0, 0);
    core_en = 1'b1;
    start_job(MODE_ECB, 1'b1, '0, 16'd0);
    chk_b("to_err_cleared", err, 1'b0);
    chk_b("zero_job_done", done, 1'b1);
    tick();
    chk_b("zero_job_idle", busy, 1'b0);

    // Abort in WAIT, core_done arrives afterwards.
    d0 = done_cnt;
    start_job(MODE_CBC, 1'b1, 128'h3, 16'd2);
    feed(A, '0, A ^ 128'h3, 1'b0);
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk_b("abort_idle", busy, 1'b0);
    chk_b("abort_out_valid", bus.out_valid, 1'b0);
    repeat (6) tick();
    chk_b("abort_still_idle", busy, 1'b0);
    chk_i("abort_done_pulses", done_cnt - d0, 0);
    chk_b("abort_err", err, 1'b0);
    start_job(MODE_ECB, 1'b0, '0, 16'd0);
    chk_b("abort_zero_job_done", done, 1'b1);
    tick();

    // Start and Abort together: Abort wins.
    BlkCount = 16'd3;
    Start = 1'b1;
    Abort = 1'b1;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    chk_b("start_abort_idle", busy, 1'b0);

    // Asynchronous reset mid-job.
    start_job(MODE_CBC, 1'b1, 128'h7, 16'd2);
    feed(B, '0, B ^ 128'h7, 1'b0);
    tick();
    RstN = 1'b0;
    #1;
    chk_b("arst_busy", busy, 1'b0);
    chk_i("arst_remaining", int'(remaining), 0);
    chk("arst_core_din", bus.core_din, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibr128_seq.md
Name: ibr128_seq

Overview:
Multi-block sequencer for the IBR128 cipher core. It streams 128-bit blocks in from an input handshake and issues one core operation per block. It applies the chaining mode (ECB/CBC/CTR) around the core by XOR and counter logic, then streams results out with backpressure. It sits between the CSR/DMA data path and the core, and always drives the core as a single-block ECB engine.

Parameters:
BLK_W, 128, block width in bits (fixed at 128, declared for readability)
CNT_W, 16, width of block count and remaining-count
TO_CYCLES, 1024, maximum cycles in WAIT before timeout error

Ports:
Clk  in  1  clock
RstN  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse; begins a job (ignored unless IDLE)
Abort  in  1  synchronous abort; returns to IDLE next cycle
Encrypt  in  1  1 = encrypt, 0 = decrypt; sampled at Start
Mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved (treated as ECB); sampled at Start
IV  in  128  initial chain value or counter; sampled at Start
BlkCount  in  CNT_W  number of blocks; sampled at Start
in_valid / in_ready  in / out  1  input block handshake
in_data  in  128  input block
out_valid / out_ready  out / in  1  output block handshake
out_data  out  128  output block
core_start  out  1  one-cycle launch pulse to core
core_encrypt  out  1  core direction
core_din  out  128  core input; held stable from core_start until core_done
core_done  in  1  one-cycle pulse; core_dout valid that cycle
core_dout  in  128  core result
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job completion
err  out  1  sticky timeout flag; cleared by next accepted Start
remaining  out  CNT_W  blocks not yet emitted

Behaviour:
- Reset: state IDLE. All outputs 0. Chain, counter and remaining registers cleared.
- States: IDLE, LOAD, START, WAIT, OUT, DONE.
- IDLE + Start:
  - Latch Encrypt, Mode, IV→chain, BlkCount→remaining; clear err.
  - BlkCount == 0 → DONE; otherwise → LOAD.
- LOAD: in_ready = 1. On in_valid, capture in_data into blk and go to START.
- START: assert core_start for exactly 1 cycle; go to WAIT. core_din is computed from registered values:
  - ECB: blk.
  - CBC encrypt: blk ^ chain.
  - CBC decrypt: blk.
  - CTR: chain (the counter).
- core_encrypt = Encrypt, except forced to 1 in CTR.
- WAIT: hold core_din. On core_done, register out_data and go to OUT:
  - ECB: core_dout.
  - CBC encrypt: core_dout; chain ← core_dout.
  - CBC decrypt: core_dout ^ chain; chain ← blk.
  - CTR: core_dout ^ blk; chain ← chain + 1, modulo 2^128 (all-ones wraps to 0).
- Timeout: a counter increments each WAIT cycle. When it reaches TO_CYCLES without core_done: err ← 1, go to IDLE, no done pulse.
- OUT: out_valid = 1 with out_data stable until out_ready. On the handshake, remaining − 1; go to DONE if remaining was 1, else LOAD.
- Input and output never overlap: in_ready = 0 outside LOAD.
- DONE: done = 1 for 1 cycle; go to IDLE.
- Per-block minimum latency from input accept to out_valid: 2 cycles plus core latency.
- Abort has priority over every transition. Next cycle: IDLE, out_valid = 0, core_start = 0, no done pulse, err unchanged.
- core_done outside WAIT is ignored.
- Start while busy is ignored.
- Start and Abort in the same cycle: Abort wins.
- RstN assertion mid-job returns to reset values immediately.

Decomposition:
- Package ibr128_pkg holds:
  - mode constants MODE_ECB / MODE_CBC / MODE_CTR;
  - state encoding enum;
  - BLK_W.
- One sub-module, ibr128_chain: a combinational mode mux plus registered chain/counter update, taking mode, encrypt, blk, chain and core_dout.
- The FSM, timeout counter and handshakes stay in ibr128_seq.

Test Plan:
Bench core model: core_dout = core_din ^ {4{32'hA5A5A5A5}} (call this K), done 3 cycles after core_start.
- ECB, 1 block, in_data = 0x0123…CDEF (128b) → out_data = in_data ^ K; done pulses once; remaining returns to 0.
- CBC encrypt, IV = 1, two blocks of 0:
  - core_din sequence: 1, then 1^K.
  - out_data sequence: 1^K, then 1.
- CBC decrypt of those outputs with the same IV → out_data 0, 0.
- CTR, IV = all-ones, two zero blocks:
  - core_din sequence: all-ones, then 0 (wrap).
  - out_data sequence: {4{32'h5A5A5A5A}}, then K.
  - core_encrypt = 1 even with Encrypt = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in OUT → out_valid stays 1, out_data stable, in_ready = 0, remaining unchanged.
- Core never signals done, TO_CYCLES = 16 → err = 1 after 16 WAIT cycles, returns to IDLE, no done pulse. The next Start clears err.
- Abort asserted in WAIT, then late core_done → IDLE, no out_valid, no done. A new Start with BlkCount = 0 → done after 1 cycle.
